norm_unit_param: RTL and testbench

//  Parametrised L1 row normaliser that sits after the SFP/accumulator stage of the 1D accelerator.

---
 rtl/norm_unit_param.sv | 136 +++++++++++++
 tb/tb_norm_unit_param.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_unit_param.sv
// L1 row normaliser: buffers signed psum rows with their |sum|, then drains each row divided by
// (sum [+ partner sum]) >> SHIFT, or unchanged in bypass mode.
module norm_unit_param #(
  parameter int COL     = 8,
  parameter int BW_PSUM = 20,
  parameter int DEPTH   = 16,
  parameter int SHIFT   = 7,
  parameter int SW      = BW_PSUM + 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       norm_en,
  input  logic                       ext_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [COL*BW_PSUM-1:0]     in_data,
  input  logic                       div_start,
  input  logic [SW-1:0]              ext_sum_in,
  output logic [SW-1:0]              sum_out,
  output logic                       sum_out_valid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COL*BW_PSUM-1:0]     out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       done
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int SW1  = SW + 1;
  localparam int ROWW = COL * BW_PSUM;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t            state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [ROWW-1:0]   row_buf [DEPTH];
  logic [SW-1:0]     sum_buf [DEPTH];

  logic              accept;
  logic              pop;
  logic [SW-1:0]     in_sum;
  logic [BW_PSUM-1:0] in_mag;
  logic [ROWW-1:0]   rd_row;
  logic [SW-1:0]     div_total;
  logic [SW-1:0]     div_d;
  logic signed [SW:0] num;
  logic signed [SW:0] den;
  logic [ROWW-1:0]   norm_row;

  assign in_ready = (state != DRAIN) && (count < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign pop      = (state == DRAIN) && (count != '0) && (!out_valid || out_ready);
  assign busy     = (state == DRAIN);

  // Magnitude of the most-negative element wraps to 2^(BW_PSUM-1), which is correct when read unsigned.
  always_comb begin
    in_sum = '0;
    in_mag = '0;
    for (int i = 0; i < COL; i++) begin
      in_mag = in_data[i*BW_PSUM +: BW_PSUM];
      if (in_mag[BW_PSUM-1]) in_mag = ~in_mag + BW_PSUM'(1);
      in_sum = in_sum + SW'(in_mag);
    end
  end

  always_comb begin
    rd_row    = row_buf[rd_ptr];
    div_total = ext_en ? sum_buf[rd_ptr] + ext_sum_in : sum_buf[rd_ptr];
    div_d     = div_total >> SHIFT;
    if (div_d == '0) div_d = SW'(1);
    den       = $signed({1'b0, div_d});
    num       = '0;
    norm_row  = '0;
    for (int i = 0; i < COL; i++) begin
      num = SW1'($signed(rd_row[i*BW_PSUM +: BW_PSUM]));
      norm_row[i*BW_PSUM +: BW_PSUM] = norm_en ? BW_PSUM'(num / den)
                                               : rd_row[i*BW_PSUM +: BW_PSUM];
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      row_buf[wr_ptr] <= in_data;
      sum_buf[wr_ptr] <= in_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      sum_out       <= '0;
      sum_out_valid <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      sum_out_valid <= accept;
      if (accept) begin
        sum_out <= in_sum;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_data  <= norm_row;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A row accepted alongside div_start is counted before the drain begins.
      case (state)
        IDLE:  if (accept) state <= FILL;
        FILL:  if (div_start && ((count != '0) || accept)) state <= DRAIN;
        DRAIN: if ((count == '0) && (!out_valid || out_ready)) begin
                 state <= IDLE;
                 done  <= 1'b1;
               end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_unit_param.sv
// Directed bench for norm_unit_param: rows are queued on acceptance and compared against a
// behavioural normaliser model when the DUT hands them over.
module tb_norm_unit_param;

  localparam int COL   = 8;
  localparam int BW    = 20;
  localparam int DEPTH = 16;
  localparam int SHIFT = 7;
  localparam int SW    = BW + 4;
  localparam int ROWW  = COL * BW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            norm_en = 1'b1;
  logic            ext_en = 1'b0;
  logic            in_valid = 1'b0;
  logic            div_start = 1'b0;
  logic            out_ready = 1'b1;
  logic [ROWW-1:0] in_data = '0;
  logic [SW-1:0]   ext_sum_in = '0;
  logic            in_ready;
  logic [SW-1:0]   sum_out;
  logic            sum_out_valid;
  logic            out_valid;
  logic [ROWW-1:0] out_data;
  logic [CW-1:0]   count;
  logic            busy;
  logic            done;

  int              checks = 0;
  int              failures = 0;
  int              rows_out = 0;
  int              rows_mark;
  logic [ROWW-1:0] sb [$];
  logic [ROWW-1:0] held_data = '0;
  bit              stall_pending = 1'b0;
  logic [ROWW-1:0] row_t;

  always #5 clk = ~clk;

  norm_unit_param #(.COL(COL), .BW_PSUM(BW), .DEPTH(DEPTH), .SHIFT(SHIFT), .SW(SW)) dut (
    .clk(clk), .reset(reset), .norm_en(norm_en), .ext_en(ext_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .div_start(div_start), .ext_sum_in(ext_sum_in),
    .sum_out(sum_out), .sum_out_valid(sum_out_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .busy(busy), .done(done)
  );

  function automatic logic [ROWW-1:0] modelRow(input logic [ROWW-1:0] row, input logic ne,
                                              input logic ee, input logic [SW-1:0] es);
    longint s, d, x, q;
    logic [ROWW-1:0] r;
    s = 0;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      x = longint'($signed(row[i*BW +: BW]));
      s += (x < 0) ? -x : x;
    end
    if (ee) s += longint'(es);
    d = (s & ((longint'(1) << SW) - 1)) >> SHIFT;
    if (d == 0) d = 1;
    for (int i = 0; i < COL; i++) begin
      x = longint'($signed(row[i*BW +: BW]));
      q = ne ? x / d : x;
      r[i*BW +: BW] = q[BW-1:0];
    end
    return r;
  endfunction

  function automatic logic [ROWW-1:0] uniformRow(input int v);
    logic [ROWW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(v);
    return r;
  endfunction

  function automatic logic [ROWW-1:0] randRow();
    logic [ROWW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'($urandom);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [ROWW-1:0] obs, input logic [ROWW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the row until accepted; optional div_start on the first presented cycle.
  task automatic applyStimulus(input logic [ROWW-1:0] row, input logic start);
    bit got;
    got = 1'b0;
    in_data   = row;
    in_valid  = 1'b1;
    div_start = start;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(row);
        got = 1'b1;
      end
      tick();
      div_start = 1'b0;
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", ROWW'(got), ROWW'(1));
  endtask

  task automatic start_drain();
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit got;
    got = 1'b0;
    for (int n = 0; n < bound && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      tick();
    end
    checkOutput("done_timeout", ROWW'(got), ROWW'(1));
  endtask

  // Returns at the negedge where out_valid is seen.
  task automatic wait_out_valid(input int bound);
    bit got;
    got = 1'b0;
    for (int n = 0; n < bound && !got; n++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else tick();
    end
    checkOutput("out_valid_timeout", ROWW'(got), ROWW'(1));
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (stall_pending) checkOutput("stall_hold", out_data, held_data);
      if (out_ready) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("[TB] FAIL unexpected_row observed=%0h expected=none", out_data);
        end
        if (sb.size() > 0) checkOutput("row", out_data, modelRow(sb.pop_front(), norm_en, ext_en, ext_sum_in));
        rows_out++;
        stall_pending = 1'b0;
      end else begin
        held_data     = out_data;
        stall_pending = 1'b1;
      end
    end else begin
      stall_pending = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=hang expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pat [4];
    bit got;
    pat = '{1, 0, 0, 1};
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_count", ROWW'(count), ROWW'(0));
    checkOutput("rst_out_valid", ROWW'(out_valid), ROWW'(0));
    checkOutput("rst_out_data", out_data, ROWW'(0));
    checkOutput("rst_sum_out", ROWW'(sum_out), ROWW'(0));
    checkOutput("rst_sum_valid", ROWW'(sum_out_valid), ROWW'(0));
    checkOutput("rst_done", ROWW'(done), ROWW'(0));
    checkOutput("rst_busy", ROWW'(busy), ROWW'(0));
    checkOutput("rst_in_ready", ROWW'(in_ready), ROWW'(1));
    tick();

    $display("[TB] uniform +128 row");
    applyStimulus(uniformRow(128), 1'b0);
    @(negedge clk);
    checkOutput("t1_sum_valid", ROWW'(sum_out_valid), ROWW'(1));
    checkOutput("t1_sum_out", ROWW'(sum_out), ROWW'(1024));
    checkOutput("t1_count", ROWW'(count), ROWW'(1));
    tick();
    start_drain();
    wait_out_valid(20);
    checkOutput("t1_data", out_data, uniformRow(16));
    checkOutput("t1_done_early", ROWW'(done), ROWW'(0));
    checkOutput("t1_sum_pulse", ROWW'(sum_out_valid), ROWW'(0));
    tick();
    @(negedge clk);
    checkOutput("t1_done", ROWW'(done), ROWW'(1));
    checkOutput("t1_idle", ROWW'(busy), ROWW'(0));
    tick();

    $display("[TB] mixed sign row and zero divisor");
    row_t = '0;
    row_t[0 +: BW]  = BW'(-300);
    row_t[BW +: BW] = BW'(300);
    applyStimulus(row_t, 1'b0);
    @(negedge clk);
    checkOutput("t2_sum_600", ROWW'(sum_out), ROWW'(600));
    tick();
    applyStimulus(uniformRow(-1), 1'b1);
    @(negedge clk);
    checkOutput("t2_sum_8", ROWW'(sum_out), ROWW'(8));
    checkOutput("t2_busy", ROWW'(busy), ROWW'(1));
    tick();
    wait_out_valid(20);
    row_t = '0;
    row_t[0 +: BW]  = BW'(-75);
    row_t[BW +: BW] = BW'(75);
    checkOutput("t2_div4", out_data, row_t);
    tick();
    @(negedge clk);
    checkOutput("t2_div1", out_data, uniformRow(-1));
    tick();
    wait_done(20);

    $display("[TB] full buffer and wrap");
    rows_mark = rows_out;
    for (int r = 0; r < DEPTH; r++) applyStimulus(randRow(), 1'b0);
    @(negedge clk);
    checkOutput("t3_full_ready", ROWW'(in_ready), ROWW'(0));
    checkOutput("t3_full_count", ROWW'(count), ROWW'(DEPTH));
    tick();
    applyStimulus(randRow(), 1'b1);
    for (int r = 0; r < 4; r++) applyStimulus(randRow(), 1'b0);
    start_drain();
    wait_done(100);
    checkOutput("t3_rows", ROWW'(rows_out - rows_mark), ROWW'(DEPTH + 5));
    checkOutput("t3_sb_empty", ROWW'(sb.size()), ROWW'(0));

    $display("[TB] output backpressure");
    rows_mark = rows_out;
    for (int r = 0; r < 6; r++) applyStimulus(randRow(), 1'b0);
    div_start = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      out_ready = pat[n % 4][0];
      @(negedge clk);
      if (done) got = 1'b1;
      tick();
      div_start = 1'b0;
    end
    out_ready = 1'b1;
    checkOutput("t4_done", ROWW'(got), ROWW'(1));
    checkOutput("t4_rows", ROWW'(rows_out - rows_mark), ROWW'(6));
    checkOutput("t4_count", ROWW'(count), ROWW'(0));

    $display("[TB] ignored start, partner sum, bypass");
    start_drain();
    @(negedge clk);
    checkOutput("t5_idle_start", ROWW'(busy), ROWW'(0));
    tick();
    ext_en     = 1'b1;
    ext_sum_in = SW'(512);
    applyStimulus(uniformRow(64), 1'b0);
    applyStimulus(randRow(), 1'b1);
    wait_out_valid(20);
    checkOutput("t5_ext", out_data, uniformRow(8));
    tick();
    wait_done(20);
    ext_en     = 1'b0;
    ext_sum_in = '0;
    norm_en    = 1'b0;
    row_t      = randRow();
    applyStimulus(row_t, 1'b0);
    applyStimulus(randRow(), 1'b1);
    wait_out_valid(20);
    checkOutput("t5_bypass", out_data, row_t);
    tick();
    wait_done(20);
    norm_en = 1'b1;

    $display("[TB] reset during drain");
    for (int r = 0; r < 5; r++) applyStimulus(randRow(), 1'b0);
    out_ready = 1'b0;
    start_drain();
    tick();
    tick();
    tick();
    @(negedge clk);
    checkOutput("t6_pre_count", ROWW'(count), ROWW'(4));
    checkOutput("t6_pre_valid", ROWW'(out_valid), ROWW'(1));
    tick();
    reset = 1'b1;
    sb.delete();
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_count", ROWW'(count), ROWW'(0));
    checkOutput("t6_out_valid", ROWW'(out_valid), ROWW'(0));
    checkOutput("t6_busy", ROWW'(busy), ROWW'(0));
    checkOutput("t6_in_ready", ROWW'(in_ready), ROWW'(1));
    tick();
    rows_mark = rows_out;
    applyStimulus(randRow(), 1'b0);
    applyStimulus(randRow(), 1'b0);
    applyStimulus(randRow(), 1'b1);
    wait_done(30);
    checkOutput("t6_rows", ROWW'(rows_out - rows_mark), ROWW'(3));
    checkOutput("final_sb_empty", ROWW'(sb.size()), ROWW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
